// File: rtl/pattern_sequencer.sv
// Test-pattern sequencer for a video generator. Host requests are applied at the next
// frame start. Without a pending request, auto mode can step the pattern 0->1->2->3->0.
module pattern_sequencer #(
    parameter int DWELL_W = 8,
    parameter int FCNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               video_vsync_i,
    input  logic               req_valid_i,
    input  logic [1:0]         req_pattern_i,
    output logic               req_ready_o,
    input  logic               auto_en_i,
    input  logic [DWELL_W-1:0] dwell_frames_i,
    output logic [1:0]         video_pattern_o,
    output logic               switch_pulse_o,
    output logic               busy_o,
    output logic [FCNT_W-1:0]  frame_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AUTO = 2'd1,
        ST_PEND = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                vsync_q;
    logic [1:0]          pend_pat_q, pend_pat_d;
    logic [1:0]          pattern_q, pattern_d;
    logic                pulse_q, pulse_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [FCNT_W-1:0]   fcount_q, fcount_d;

    logic                fs_s;
    logic                accept_s;
    logic [DWELL_W-1:0]  dwell_lim_s;
    logic [DWELL_W:0]    dwell_inc_s;
    logic                dwell_hit_s;

    assign fs_s        = vsync_q & ~video_vsync_i;
    assign req_ready_o = ~rst & (state_q != ST_PEND);
    assign accept_s    = req_valid_i & req_ready_o;

    // A dwell of zero behaves as one frame; compare one bit wider so cnt+1 cannot overflow.
    assign dwell_lim_s = (dwell_frames_i == {DWELL_W{1'b0}}) ?
                         {{(DWELL_W-1){1'b0}}, 1'b1} : dwell_frames_i;
    assign dwell_inc_s = {1'b0, dwell_q} + {{DWELL_W{1'b0}}, 1'b1};
    assign dwell_hit_s = (dwell_inc_s >= {1'b0, dwell_lim_s});

    // Next-state and datapath decisions; acceptance outranks everything else.
    always_comb begin
        state_d    = state_q;
        pend_pat_d = pend_pat_q;
        pattern_d  = pattern_q;
        pulse_d    = 1'b0;
        dwell_d    = dwell_q;
        fcount_d   = fs_s ? (fcount_q + {{(FCNT_W-1){1'b0}}, 1'b1}) : fcount_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    pend_pat_d = req_pattern_i;
                    state_d    = ST_PEND;
                end else if (auto_en_i) begin
                    state_d = ST_AUTO;
                    dwell_d = {DWELL_W{1'b0}};
                end else begin
                    dwell_d = {DWELL_W{1'b0}};
                end
            end
            ST_AUTO: begin
                if (accept_s) begin
                    pend_pat_d = req_pattern_i;
                    state_d    = ST_PEND;
                end else if (!auto_en_i) begin
                    state_d = ST_IDLE;
                    dwell_d = {DWELL_W{1'b0}};
                end else if (fs_s) begin
                    if (dwell_hit_s) begin
                        pattern_d = pattern_q + 2'd1;
                        dwell_d   = {DWELL_W{1'b0}};
                        pulse_d   = 1'b1;
                    end else begin
                        dwell_d = dwell_inc_s[DWELL_W-1:0];
                    end
                end else begin
                    dwell_d = dwell_q;
                end
            end
            ST_PEND: begin
                if (fs_s) begin
                    pattern_d = pend_pat_q;
                    pulse_d   = 1'b1;
                    dwell_d   = {DWELL_W{1'b0}};
                    state_d   = auto_en_i ? ST_AUTO : ST_IDLE;
                end else begin
                    state_d = ST_PEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
                dwell_d = {DWELL_W{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            vsync_q    <= 1'b0;
            pend_pat_q <= 2'd0;
            pattern_q  <= 2'd0;
            pulse_q    <= 1'b0;
            dwell_q    <= {DWELL_W{1'b0}};
            fcount_q   <= {FCNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            vsync_q    <= video_vsync_i;
            pend_pat_q <= pend_pat_d;
            pattern_q  <= pattern_d;
            pulse_q    <= pulse_d;
            dwell_q    <= dwell_d;
            fcount_q   <= fcount_d;
        end
    end

    assign video_pattern_o = pattern_q;
    assign switch_pulse_o  = pulse_q;
    assign busy_o          = (state_q == ST_PEND);
    assign frame_count_o   = fcount_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: directed scenarios plus random frames, each cycle compared
// against a frame-level reference model. The frame counter is narrowed so wrap is reachable.
module tb_pattern_sequencer;

    localparam int DW = 8;
    localparam int FW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          video_vsync;
    logic          req_valid;
    logic [1:0]    req_pattern;
    logic          req_ready;
    logic          auto_en;
    logic [DW-1:0] dwell;
    logic [1:0]    video_pattern;
    logic          switch_pulse;
    logic          busy;
    logic [FW-1:0] frame_count;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses_seen = 0;

    // reference model state
    int m_prev_vs, m_pending, m_pend_pat, m_auto, m_cnt, m_pat, m_pulse, m_fc;

    pattern_sequencer #(.DWELL_W(DW), .FCNT_W(FW)) dut (
        .clk             (clk),
        .rst             (rst),
        .video_vsync_i   (video_vsync),
        .req_valid_i     (req_valid),
        .req_pattern_i   (req_pattern),
        .req_ready_o     (req_ready),
        .auto_en_i       (auto_en),
        .dwell_frames_i  (dwell),
        .video_pattern_o (video_pattern),
        .switch_pulse_o  (switch_pulse),
        .busy_o          (busy),
        .frame_count_o   (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of the reference: what the sequencer should show after this edge.
    task automatic model_step();
        int fs, eff, was_pending;
        if (rst) begin
            m_prev_vs = 0; m_pending = 0; m_pend_pat = 0; m_auto = 0;
            m_cnt = 0; m_pat = 0; m_pulse = 0; m_fc = 0;
        end else begin
            fs = (!video_vsync && m_prev_vs != 0) ? 1 : 0;
            m_prev_vs = video_vsync ? 1 : 0;
            m_pulse = 0;
            if (fs != 0) m_fc = (m_fc + 1) % (1 << FW);
            was_pending = m_pending;
            if (was_pending != 0) begin
                if (fs != 0) begin
                    m_pat = m_pend_pat; m_pulse = 1; m_cnt = 0;
                    m_pending = 0; m_auto = auto_en ? 1 : 0;
                end
            end else if (req_valid) begin
                m_pending = 1; m_pend_pat = int'(req_pattern);
            end else if (m_auto == 0) begin
                m_cnt = 0;
                if (auto_en) m_auto = 1;
            end else if (!auto_en) begin
                m_auto = 0; m_cnt = 0;
            end else if (fs != 0) begin
                eff = (dwell == 0) ? 1 : int'(dwell);
                if (m_cnt + 1 >= eff) begin
                    m_pat = (m_pat + 1) % 4; m_cnt = 0; m_pulse = 1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
    endtask

    task automatic tick();
        #1;
        check_eq("ready", req_ready, (!rst && m_pending == 0) ? 1 : 0);
        model_step();
        @(posedge clk);
        #1;
        if (switch_pulse) pulses_seen++;
        check_eq("pattern", video_pattern, m_pat);
        check_eq("pulse", switch_pulse, m_pulse);
        check_eq("busy", busy, m_pending);
        check_eq("frame_count", frame_count, m_fc);
    endtask

    // vsync high for hi cycles then low for lo; a request is offered at cycle index req_at (-1 none).
    task automatic run_frame(input int hi, input int lo, input int req_at, input logic [1:0] rp);
        for (int i = 0; i < hi + lo; i++) begin
            video_vsync = (i < hi);
            req_valid   = (i == req_at);
            req_pattern = rp;
            tick();
        end
        req_valid = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; video_vsync = 1'b1; req_valid = 1'b0; req_pattern = 2'd0;
        auto_en = 1'b0; dwell = '0;
        do_reset(3);
        check_eq("reset_pattern", video_pattern, 0);
        check_eq("reset_fc", frame_count, 0);

        // three idle frames: count only
        pulses_seen = 0;
        for (int f = 0; f < 3; f++) run_frame(6, 2, -1, 2'd0);
        check_eq("idle_fc3", frame_count, 3);
        check_eq("idle_pulses", pulses_seen, 0);

        // host request mid-frame, applied at next frame start
        pulses_seen = 0;
        run_frame(6, 2, 3, 2'd2);
        check_eq("req_applied", video_pattern, 2);
        check_eq("req_one_pulse", pulses_seen, 1);

        // auto with dwell 2 from pattern 0
        do_reset(2);
        auto_en = 1'b1; dwell = 8'd2; pulses_seen = 0;
        for (int f = 0; f < 8; f++) run_frame(6, 2, -1, 2'd0);
        check_eq("auto_wrap_pattern", video_pattern, 0);
        check_eq("auto_pulses", pulses_seen, 4);

        // dwell 0 steps each frame
        dwell = '0;
        for (int f = 0; f < 5; f++) run_frame(4, 2, -1, 2'd0);

        // request exactly in the frame-start cycle, same value included
        auto_en = 1'b0;
        run_frame(4, 2, -1, 2'd0);
        run_frame(5, 2, 5, 2'd3);
        run_frame(5, 2, 5, 2'd3);
        run_frame(5, 2, -1, 2'd0);

        // reset while pending discards the request
        run_frame(6, 2, 2, 2'd1);
        video_vsync = 1'b1; req_valid = 1'b1; req_pattern = 2'd1; tick();
        req_valid = 1'b0;
        do_reset(1);
        check_eq("rst_pend_busy", busy, 0);
        check_eq("rst_pend_pattern", video_pattern, 0);
        pulses_seen = 0;
        run_frame(5, 2, -1, 2'd0);
        check_eq("rst_pend_no_apply", pulses_seen, 0);
        check_eq("rst_pend_fc", frame_count, 1);

        // random traffic
        for (int f = 0; f < 150; f++) begin
            int hi, lo, ra;
            hi = int'($urandom_range(8, 1));
            lo = int'($urandom_range(3, 1));
            ra = ($urandom_range(2, 0) == 0) ? int'($urandom_range(hi + lo - 1, 0)) : -1;
            if ($urandom_range(4, 0) == 0) auto_en = ~auto_en;
            dwell = DW'($urandom_range(3, 0));
            if ($urandom_range(29, 0) == 0) do_reset(1);
            run_frame(hi, lo, ra, 2'($urandom_range(3, 0)));
        end

        // long run to wrap the frame counter
        do_reset(1);
        auto_en = 1'b0;
        for (int f = 0; f < 260; f++) run_frame(1, 1, -1, 2'd0);
        check_eq("fc_wrap", frame_count, 260 % 256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
